// File: rtl/lsu_unit_pkg.sv
// rtl/lsu_unit_pkg.sv - shared CPU types for the load/store unit: width codes, FSM states, size helpers
package lsu_unit_pkg;

  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_D  = 3'b011,
    MW_BU = 3'b100,
    MW_HU = 3'b101,
    MW_WU = 3'b110
  } mem_width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } mem_size_e;

  // Access size of a width code; the unused code 111 behaves as a doubleword.
  function automatic mem_size_e width_size(input logic [2:0] w);
    case (w)
      MW_B, MW_BU: return SZ_B;
      MW_H, MW_HU: return SZ_H;
      MW_W, MW_WU: return SZ_W;
      default:     return SZ_D;
    endcase
  endfunction

  // Only the plain B/H/W loads sign-extend.
  function automatic logic width_signed(input logic [2:0] w);
    return (w == MW_B) || (w == MW_H) || (w == MW_W);
  endfunction

  // True when the access does not sit on its natural size boundary.
  function automatic logic lsu_misaligned(input logic [2:0] w, input logic [2:0] lane);
    case (width_size(w))
      SZ_H:    return lane[0];
      SZ_W:    return |lane[1:0];
      SZ_D:    return |lane;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// rtl/lsu_unit_if.sv - core-side request/response bundle of the load/store unit
interface lsu_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_width;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_width, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_width, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane mask, store data shift and load extract/extend
module lsu_align
  import lsu_unit_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [2:0]  lane,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] wdata_sh,
  output logic [7:0]  wmask,
  output logic [63:0] rdata_ext
);

  logic [5:0]  bit_off;
  logic [63:0] rsh;
  logic        sgn;

  assign bit_off = {lane, 3'b000};
  assign sgn     = width_signed(width);

  // Move store data/mask up to the addressed lane and bring load data down to bit 0.
  always_comb begin
    wdata_sh  = wdata << bit_off;
    rsh       = rdata >> bit_off;
    wmask     = 8'hFF << lane;
    rdata_ext = rsh;
    case (width_size(width))
      SZ_B: begin
        wmask     = 8'h01 << lane;
        rdata_ext = {{56{sgn & rsh[7]}}, rsh[7:0]};
      end
      SZ_H: begin
        wmask     = 8'h03 << lane;
        rdata_ext = {{48{sgn & rsh[15]}}, rsh[15:0]};
      end
      SZ_W: begin
        wmask     = 8'h0F << lane;
        rdata_ext = {{32{sgn & rsh[31]}}, rsh[31:0]};
      end
      default: begin
        wmask     = 8'hFF << lane;
        rdata_ext = rsh;
      end
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - single-outstanding load/store unit; LSU_MISALIGN_TRAP_EN enables misaligned-access trapping
module lsu_unit
  import lsu_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  lsu_unit_if.slave   core,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [63:0] dmem_rdata
);

  lsu_state_e  state;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic        we_q;
  logic [2:0]  width_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_ext;
  logic        misalign;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = lsu_misaligned(core.req_width, core.req_addr[2:0]);
`else
  assign misalign = 1'b0;
`endif

  lsu_align u_align (
    .width     (width_q),
    .lane      (addr_q[2:0]),
    .wdata     (wdata_q),
    .rdata     (dmem_rdata),
    .wdata_sh  (dmem_wdata),
    .wmask     (dmem_wmask),
    .rdata_ext (rdata_ext)
  );

  assign dmem_addr       = {addr_q[63:3], 3'b000};
  assign dmem_we         = we_q;
  assign core.req_ready  = req_ready_q;
  assign core.resp_valid = resp_valid_q;
  assign core.resp_rdata = resp_rdata_q;
  assign core.resp_err   = resp_err_q;

  // Request sequencer: accept, hold the memory strobe until granted, wait for data, respond once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      req_ready_q  <= 1'b1;
      dmem_req     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      width_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (core.req_valid && req_ready_q) begin
            we_q        <= core.req_we;
            width_q     <= core.req_width;
            addr_q      <= core.req_addr;
            wdata_q     <= core.req_wdata;
            req_ready_q <= 1'b0;
            if (misalign) begin
              state        <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state    <= S_REQ;
              dmem_req <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (we_q) begin
              state        <= S_DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dmem_rvalid) begin
            state        <= S_DONE;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rdata_ext;
            resp_err_q   <= 1'b0;
          end
        end
        S_DONE: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b1;
          dmem_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - directed self-checking bench for lsu_unit
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  int errors = 0;
  int checks = 0;

  lsu_unit_if bus ();

  lsu_unit dut (
    .clk         (clk),
    .rst         (rst),
    .core        (bus),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_wmask  (dmem_wmask),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial forever #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op and play the memory side: grant after gw REQ cycles, rvalid after rw WAIT cycles.
  task automatic run_op(input logic we, input logic [2:0] w, input logic [63:0] a,
                        input logic [63:0] wd, input int gw, input int rw, input logic [63:0] rd,
                        output int lat, output logic saw_req, output logic [63:0] o_addr,
                        output logic [7:0] o_mask, output logic [63:0] o_wdata, output logic o_we);
    int   gc;
    int   rc;
    logic inwait;
    logic gave;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_width = w;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
    o_addr  = dmem_addr;
    o_mask  = dmem_wmask;
    o_wdata = dmem_wdata;
    o_we    = dmem_we;
    saw_req = dmem_req;
    lat     = 1;
    gc      = 0;
    rc      = 0;
    inwait  = 1'b0;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      gave        = 1'b0;
      if (dmem_req === 1'b1) begin
        saw_req = 1'b1;
        if (gc == gw) begin
          dmem_gnt = 1'b1;
          gave     = 1'b1;
        end
        gc++;
      end else if (inwait) begin
        if (rc == rw) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rd;
        end
        rc++;
      end
      step();
      if (gave && !we) inwait = 1'b1;
      lat++;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic post_op(input string tag);
    step();
    chk({tag, "_ready_back"}, bus.req_ready, 1'b1);
    chk({tag, "_pulse_once"}, bus.resp_valid, 1'b0);
  endtask

  int          lat;
  logic        saw;
  logic [63:0] oa;
  logic [7:0]  om;
  logic [63:0] ow;
  logic        owe;

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_width = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b0;
    dmem_rdata    = '0;
    repeat (2) step();
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_rdata", bus.resp_rdata, 64'h0);
    chk("rst_err", bus.resp_err, 1'b0);
    chk("rst_dmem_req", dmem_req, 1'b0);
    chk("rst_dmem_addr", dmem_addr, 64'h0);
    chk("rst_dmem_wdata", dmem_wdata, 64'h0);
    rst = 1'b0;
    step();

    // SD 0x1000, immediate grant
    run_op(1'b1, 3'b011, 64'h1000, 64'h1122334455667788, 0, 0, 64'h0, lat, saw, oa, om, ow, owe);
    chk("sd_addr", oa, 64'h1000);
    chk("sd_mask", om, 8'hFF);
    chk("sd_wdata", ow, 64'h1122334455667788);
    chk("sd_we", owe, 1'b1);
    chk("sd_lat", lat, 2);
    chk("sd_err", bus.resp_err, 1'b0);
    post_op("sd");

    // LB 0x2003, sign bit set in selected byte
    run_op(1'b0, 3'b000, 64'h2003, 64'h0, 0, 0, 64'h00000000_80000000, lat, saw, oa, om, ow, owe);
    chk("lb_addr", oa, 64'h2000);
    chk("lb_mask", om, 8'h08);
    chk("lb_we", owe, 1'b0);
    chk("lb_lat", lat, 3);
    chk("lb_rdata", bus.resp_rdata, 64'hFFFFFFFF_FFFFFF80);
    post_op("lb");

    // LHU 0x2006 with 2 grant waits and 3 data waits
    run_op(1'b0, 3'b101, 64'h2006, 64'h0, 2, 3, 64'hBEEF1234_56789ABC, lat, saw, oa, om, ow, owe);
    chk("lhu_addr", oa, 64'h2000);
    chk("lhu_mask", om, 8'hC0);
    chk("lhu_lat", lat, 8);
    chk("lhu_rdata", bus.resp_rdata, 64'h0000000_0000BEEF);
    post_op("lhu");

    // SB 0x4005
    run_op(1'b1, 3'b000, 64'h4005, 64'hFFFFFFFF_FFFFFFAB, 0, 0, 64'h0, lat, saw, oa, om, ow, owe);
    chk("sb_mask", om, 8'h20);
    chk("sb_wdata_lane", ow[47:40], 8'hAB);
    chk("sb_lat", lat, 2);
    chk("sb_rdata_kept", bus.resp_rdata, 64'h0000000_0000BEEF);
    post_op("sb");

    // LW 0x3002, misaligned word
    run_op(1'b0, 3'b010, 64'h3002, 64'h0, 0, 0, 64'h00008000_00000000, lat, saw, oa, om, ow, owe);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lwmis_err", bus.resp_err, 1'b1);
    chk("lwmis_no_req", saw, 1'b0);
    chk("lwmis_lat", lat, 1);
    chk("lwmis_rdata_kept", bus.resp_rdata, 64'h0000000_0000BEEF);
`else
    chk("lwmis_err", bus.resp_err, 1'b0);
    chk("lwmis_req", saw, 1'b1);
    chk("lwmis_mask", om, 8'h3C);
    chk("lwmis_lat", lat, 3);
    chk("lwmis_rdata", bus.resp_rdata, 64'hFFFFFFFF_80000000);
`endif
    post_op("lwmis");

    // Width code 111 behaves as D
    run_op(1'b0, 3'b111, 64'h5000, 64'h0, 0, 0, 64'h01234567_89ABCDEF, lat, saw, oa, om, ow, owe);
    chk("w7_mask", om, 8'hFF);
    chk("w7_lat", lat, 3);
    chk("w7_rdata", bus.resp_rdata, 64'h01234567_89ABCDEF);
    chk("w7_err", bus.resp_err, 1'b0);
    post_op("w7");

    // LH 0x2002, negative half
    run_op(1'b0, 3'b001, 64'h2002, 64'h0, 0, 1, 64'h00000000_80010000, lat, saw, oa, om, ow, owe);
    chk("lh_mask", om, 8'h0C);
    chk("lh_lat", lat, 4);
    chk("lh_rdata", bus.resp_rdata, 64'hFFFFFFFF_FFFF8001);
    post_op("lh");

    // SW 0x6004, one grant wait; upper source bits shifted out
    run_op(1'b1, 3'b010, 64'h6004, 64'h12345678_DEADBEEF, 1, 0, 64'h0, lat, saw, oa, om, ow, owe);
    chk("sw_addr", oa, 64'h6000);
    chk("sw_mask", om, 8'hF0);
    chk("sw_wdata", ow, 64'hDEADBEEF_00000000);
    chk("sw_lat", lat, 3);
    post_op("sw");

    // Reset while waiting for load data
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_width = 3'b010;
    bus.req_addr  = 64'h7000;
    bus.req_wdata = '0;
    dmem_gnt      = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    dmem_gnt = 1'b0;
    chk("mid_wait_no_req", dmem_req, 1'b0);
    chk("mid_wait_not_ready", bus.req_ready, 1'b0);
    chk("mid_wait_we", dmem_we, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ready", bus.req_ready, 1'b1);
    chk("mid_rst_resp_valid", bus.resp_valid, 1'b0);
    chk("mid_rst_rdata", bus.resp_rdata, 64'h0);
    chk("mid_rst_addr", dmem_addr, 64'h0);
    dmem_rvalid = 1'b1;
    dmem_gnt    = 1'b1;
    dmem_rdata  = 64'hFFFFFFFF_FFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_resp_valid", bus.resp_valid, 1'b0);
      chk("stray_dmem_req", dmem_req, 1'b0);
    end
    dmem_rvalid = 1'b0;
    dmem_gnt    = 1'b0;
    chk("stray_rdata", bus.resp_rdata, 64'h0);
    chk("stray_ready", bus.req_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
